sc_fetch_unit: RTL and testbench
================================

// Module: sc_fetch_unit
// PURPOSE
//  Instruction-fetch / next-PC stage feeding the single-cycle control unit and datapath.
//  Holds the PC and fetches each instruction over a ready-handshaked instruction memory.
//  Presents the instruction (op/func fields go to the control unit) until the core commits.
//  Forms the next PC from the control unit's pcsource and flags timeout or misaligned-PC faults.
// PARAMETERS
//  PC_RESET  32'h0000_0000  PC loaded on reset (word aligned)
//  MAX_WAIT  15             max FETCH cycles without imem_ready before fault; 0 = no timeout
// PORTS
//  clock       in   1   rising-edge clock
//  resetn      in   1   asynchronous active-low reset
//  pcsource    in   2   00 pc+4, 01 branch, 10 jr (da), 11 jump/jal; sampled on commit
//  da          in   32  register rs value, jr target
//  commit      in   1   core finished current instruction; advance PC
//  imem_req    out  1   fetch request; imem_addr valid while high
//  imem_addr   out  32  fetch address (= pc)
//  imem_ready  in   1   imem_rdata valid this cycle
//  imem_rdata  in   32  fetched instruction word
//  inst        out  32  latched instruction
//  inst_valid  out  1   inst holds a fetched instruction awaiting commit
//  pc          out  32  current PC
//  pc4         out  32  pc + 4 (mod 2^32), link value for jal
//  icount      out  32  committed-instruction count (wraps)
//  fetch_err   out  1   sticky fault flag
// BEHAVIOUR
//  Reset (async, resetn=0): state=BOOT, pc=PC_RESET, inst=0, inst_valid=0, icount=0,
//   fetch_err=0, wait counter=0; imem_req=0. All outputs take these values immediately.
//  States: BOOT, FETCH, EXEC, ERR. imem_req = (state==FETCH); imem_addr = pc always.
//  BOOT: single cycle after reset release -> FETCH.
//  FETCH: imem_req=1. If imem_ready: inst<=imem_rdata, inst_valid<=1, wait cnt<=0 -> EXEC.
//   Else cnt<=cnt+1; if MAX_WAIT!=0 and this is the MAX_WAIT-th consecutive FETCH cycle
//   without ready: fetch_err<=1 -> ERR. Ready on the MAX_WAIT-th cycle is accepted.
//  EXEC: inst_valid=1, inst stable. On commit: pc<=next_pc, icount<=icount+1,
//   inst_valid<=0 -> FETCH; if next_pc[1:0]!=0: pc still loads, fetch_err<=1 -> ERR instead.
//  ERR: imem_req=0, inst_valid=0, all inputs ignored; exits only by reset.
//  commit ignored outside EXEC; imem_ready/imem_rdata ignored outside FETCH.
//  next_pc (combinational from pc, inst, da, pcsource):
//   00: pc4; 01: pc4 + {{14{inst[15]}}, inst[15:0], 2'b00};
//   10: da; 11: {pc4[31:28], inst[25:0], 2'b00}. All adds 32-bit, wrap mod 2^32.
//  Latency: commit in cycle t -> imem_req with new address in t+1; ready in t+1 ->
//   inst_valid in t+2. Minimum 2 cycles per instruction.
//  pc4 is combinational from pc; valid in every state including reset.
// TESTING
//  Reset/boot: PC_RESET=0; release resetn -> cycle1 imem_req=0, cycle2 imem_req=1,
//   addr=0x0; ready, rdata=0x20010005 -> next cycle inst=0x20010005, inst_valid=1.
//  Sequential: commit with pcsource=00 at pc=0x0 -> imem_addr=0x4 next cycle, icount=1.
//  Branch/jump: pc=0x10, inst=0x1000FFFF, pcsource=01 -> next addr 0x10; pc=0x10,
//   inst=0x08000040, pcsource=11 -> 0x100; pcsource=10, da=0x200 -> 0x200.
//  Misaligned jr: pcsource=10, da=0x22, commit -> fetch_err=1, imem_req=0, stays in ERR
//   for 20 cycles despite commit/ready activity; resetn pulse clears it.
//  Timeout (MAX_WAIT=4): ready low 4 FETCH cycles -> fetch_err=1; repeat with ready on
//   the 4th cycle -> instruction accepted, fetch_err=0.
//  Reset mid-fetch: drop resetn while imem_req=1 and in EXEC -> same cycle imem_req=0,
//   inst_valid=0, pc=PC_RESET, icount=0; refetch from PC_RESET after release.

Source files
------------

// File: rtl/sc_fetch_unit.sv
// Instruction-fetch / next-PC stage for the single-cycle core.
// Fetches over a ready handshake, holds inst until commit, flags faults.
module sc_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] da,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] icount,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    EXEC,
    ERR
  } state_t;

  state_t      state;
  logic [31:0] wcnt;
  logic [31:0] wcnt_nx;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        timeout;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign wcnt_nx   = wcnt + 32'd1;
  assign br_off    = {{14{inst[15]}}, inst[15:0], 2'b00};

  // Zero MAX_WAIT disables the fetch watchdog.
  assign timeout = (MAX_WAIT != 0) && (wcnt_nx == MAX_WAIT);

  always_comb begin
    next_pc = pc4;
    unique case (pcsource)
      2'b00: next_pc = pc4;
      2'b01: next_pc = pc4 + br_off;
      2'b10: next_pc = da;
      2'b11: next_pc = {pc4[31:28], inst[25:0], 2'b00};
      default: next_pc = pc4;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= BOOT;
      pc         <= PC_RESET;
      inst       <= '0;
      inst_valid <= 1'b0;
      icount     <= '0;
      fetch_err  <= 1'b0;
      wcnt       <= '0;
    end else begin
      unique case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            wcnt       <= '0;
            state      <= EXEC;
          end else begin
            wcnt <= wcnt_nx;
            if (timeout) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end
          end
        end
        EXEC: begin
          if (commit) begin
            pc         <= next_pc;
            icount     <= icount + 32'd1;
            inst_valid <= 1'b0;
            // Misaligned target still lands in pc for post-mortem.
            if (next_pc[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              state <= FETCH;
            end
          end
        end
        ERR: state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_fetch_unit.sv
// Directed bench for sc_fetch_unit: boot, next-PC forms, faults, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sc_fetch_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] da;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] icount;
  logic        fetch_err;

  int vecs = 0;
  int errs = 0;

  sc_fetch_unit #(
    .PC_RESET(32'h0000_0000),
    .MAX_WAIT(4)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pcsource  (pcsource),
    .da        (da),
    .commit    (commit),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .inst      (inst),
    .inst_valid(inst_valid),
    .pc        (pc),
    .pc4       (pc4),
    .icount    (icount),
    .fetch_err (fetch_err)
  );

  always #5 clock = ~clock;

  // Reset pulse ending with the DUT in its first FETCH cycle.
  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    commit = 1'b0;
    imem_ready = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  // One-cycle ready with the given word; ends in EXEC.
  task automatic fetch(input logic [31:0] w);
    imem_ready = 1'b1;
    imem_rdata = w;
    @(negedge clock);
    imem_ready = 1'b0;
  endtask

  // One-cycle commit; ends in FETCH (or ERR).
  task automatic do_commit(input logic [1:0] src,
                           input logic [31:0] d);
    commit = 1'b1;
    pcsource = src;
    da = d;
    @(negedge clock);
    commit = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    vecs++;
    if ({imem_req, inst_valid, fetch_err} !== 3'b000) begin
      $display("FAIL reset_flags: got %b want 000",
               {imem_req, inst_valid, fetch_err});
      errs++;
    end
    vecs++;
    if ({pc, pc4, inst, icount} !== {32'h0, 32'h4, 32'h0, 32'h0}) begin
      $display("FAIL reset_regs: pc=%h pc4=%h inst=%h ic=%h want 0/4/0/0",
               pc, pc4, inst, icount);
      errs++;
    end
    @(negedge clock);
    resetn = 1'b1;
    vecs++;
    if (imem_req !== 1'b0) begin
      $display("FAIL boot_cycle1: req=%b want 0", imem_req);
      errs++;
    end
    @(negedge clock);
    vecs++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL boot_cycle2: req=%b addr=%h want 1/0",
               imem_req, imem_addr);
      errs++;
    end
    fetch(32'h2001_0005);
    vecs++;
    if ({inst_valid, inst, imem_req} !== {1'b1, 32'h2001_0005, 1'b0}) begin
      $display("FAIL boot_fetch: v=%b inst=%h req=%b want 1/20010005/0",
               inst_valid, inst, imem_req);
      errs++;
    end
  endtask

  task automatic test_sequential();
    // ready in EXEC must not disturb the held instruction
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    imem_ready = 1'b0;
    vecs++;
    if ({inst_valid, inst} !== {1'b1, 32'h2001_0005}) begin
      $display("FAIL exec_ignores_ready: v=%b inst=%h want 1/20010005",
               inst_valid, inst);
      errs++;
    end
    do_commit(2'b00, 32'h0);
    vecs++;
    if ({imem_req, imem_addr, icount, inst_valid} !==
        {1'b1, 32'h4, 32'h1, 1'b0}) begin
      $display("FAIL seq: req=%b addr=%h ic=%h v=%b want 1/4/1/0",
               imem_req, imem_addr, icount, inst_valid);
      errs++;
    end
    // commit during FETCH must be ignored
    do_commit(2'b10, 32'h80);
    vecs++;
    if ({imem_req, pc, icount} !== {1'b1, 32'h4, 32'h1}) begin
      $display("FAIL fetch_ignores_commit: req=%b pc=%h ic=%h want 1/4/1",
               imem_req, pc, icount);
      errs++;
    end
  endtask

  task automatic test_branch_jump();
    fetch(32'h0000_0000);
    do_commit(2'b10, 32'h10);
    fetch(32'h1000_FFFF);
    do_commit(2'b01, 32'h0);
    vecs++;
    if ({imem_addr, icount} !== {32'h10, 32'h3}) begin
      $display("FAIL branch_back: addr=%h ic=%h want 10/3",
               imem_addr, icount);
      errs++;
    end
    fetch(32'h0800_0040);
    do_commit(2'b11, 32'h0);
    vecs++;
    if (imem_addr !== 32'h100) begin
      $display("FAIL jump: addr=%h want 100", imem_addr);
      errs++;
    end
    fetch(32'h0000_0008);
    do_commit(2'b10, 32'h200);
    vecs++;
    if ({imem_addr, pc4, icount, fetch_err} !==
        {32'h200, 32'h204, 32'h5, 1'b0}) begin
      $display("FAIL jr: addr=%h pc4=%h ic=%h err=%b want 200/204/5/0",
               imem_addr, pc4, icount, fetch_err);
      errs++;
    end
  endtask

  task automatic test_misaligned();
    fetch(32'h0000_0008);
    do_commit(2'b10, 32'h22);
    vecs++;
    if ({fetch_err, imem_req, inst_valid, pc} !==
        {1'b1, 1'b0, 1'b0, 32'h22}) begin
      $display("FAIL misalign: err=%b req=%b v=%b pc=%h want 1/0/0/22",
               fetch_err, imem_req, inst_valid, pc);
      errs++;
    end
    for (int i = 0; i < 20; i++) begin
      commit = i[0];
      imem_ready = ~i[0];
      imem_rdata = 32'h1234_0000 + i;
      pcsource = 2'b00;
      @(negedge clock);
      vecs++;
      if ({fetch_err, imem_req, inst_valid, pc, icount} !==
          {3'b100, 32'h22, 32'h6}) begin
        $display("FAIL err_sticky[%0d]: err=%b req=%b v=%b pc=%h ic=%h",
                 i, fetch_err, imem_req, inst_valid, pc, icount);
        errs++;
      end
    end
    commit = 1'b0;
    imem_ready = 1'b0;
    do_reset();
    vecs++;
    if ({fetch_err, imem_req, pc, icount} !==
        {1'b0, 1'b1, 32'h0, 32'h0}) begin
      $display("FAIL err_clear: err=%b req=%b pc=%h ic=%h want 0/1/0/0",
               fetch_err, imem_req, pc, icount);
      errs++;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (3) @(negedge clock);
    vecs++;
    if ({fetch_err, imem_req} !== 2'b01) begin
      $display("FAIL timeout_early: err=%b req=%b want 0/1",
               fetch_err, imem_req);
      errs++;
    end
    @(negedge clock);
    vecs++;
    if ({fetch_err, imem_req} !== 2'b10) begin
      $display("FAIL timeout: err=%b req=%b want 1/0",
               fetch_err, imem_req);
      errs++;
    end
    do_reset();
    repeat (3) @(negedge clock);
    fetch(32'hCAFE_0001);
    vecs++;
    if ({fetch_err, inst_valid, inst} !== {2'b01, 32'hCAFE_0001}) begin
      $display("FAIL ready_last: err=%b v=%b inst=%h want 0/1/cafe0001",
               fetch_err, inst_valid, inst);
      errs++;
    end
  endtask

  task automatic test_reset_midfetch();
    do_commit(2'b00, 32'h0);
    resetn = 1'b0;
    #1;
    vecs++;
    if ({imem_req, inst_valid, pc, icount} !== {2'b00, 32'h0, 32'h0}) begin
      $display("FAIL rst_fetch: req=%b v=%b pc=%h ic=%h want 0/0/0/0",
               imem_req, inst_valid, pc, icount);
      errs++;
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    fetch(32'h0000_0011);
    do_commit(2'b00, 32'h0);
    fetch(32'h0000_0022);
    resetn = 1'b0;
    #1;
    vecs++;
    if ({imem_req, inst_valid, pc, icount, inst} !==
        {2'b00, 32'h0, 32'h0, 32'h0}) begin
      $display("FAIL rst_exec: req=%b v=%b pc=%h ic=%h inst=%h",
               imem_req, inst_valid, pc, icount, inst);
      errs++;
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    vecs++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      $display("FAIL refetch: req=%b addr=%h want 1/0",
               imem_req, imem_addr);
      errs++;
    end
  endtask

  initial begin
    resetn = 1'b0;
    pcsource = 2'b00;
    da = 32'h0;
    commit = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_branch_jump();
    test_misaligned();
    test_timeout();
    test_reset_midfetch();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
